// File: rtl/adc_lvds_frame_tx.sv
// adc_lvds_frame_tx
// Transmit-side word generator for an 8x / 2-wire LVDS serializer carrying
// 16-bit ADC samples. After the serializer PLL locks, it sends a training
// phase: the frame pattern on the frame lane and a fixed test word on the
// data lanes. It then streams samples. A bit-rotation offset can be injected
// so that a receive-side bitslip aligner can be exercised in loopback.
//
// Ports:
//   clk           word clock (serializer parallel clock)
//   reset_n       asynchronous active-low reset
//   tx_pll_locked serializer PLL lock, synchronous to clk
//   train_req     single-cycle pulse, restarts training (ignored in IDLE)
//   sample_data   16-bit sample, [15:8] -> lane A, [7:0] -> lane B
//   sample_valid  sample_data is valid
//   sample_ready  combinational, high while streaming (RUN)
//   slip_inject   pulse, rotates all lanes by one more bit (rate limited)
//   frm_out       frame lane word
//   lane_a_out    data lane A word
//   lane_b_out    data lane B word
//   training      high while in TRAIN
//   underflow     high for a cycle after a RUN cycle without a valid sample
//   rot_offset    current injected rotation (0..7)
module adc_lvds_frame_tx #(
  parameter int          TRAIN_CYCLES  = 64,
  parameter logic [7:0]  FRAME_PATTERN = 8'hF0,
  parameter logic [15:0] TEST_PATTERN  = 16'hA5C3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx_pll_locked,
  input  logic        train_req,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        slip_inject,
  output logic [7:0]  frm_out,
  output logic [7:0]  lane_a_out,
  output logic [7:0]  lane_b_out,
  output logic        training,
  output logic        underflow,
  output logic [2:0]  rot_offset
);

  localparam int CW = (TRAIN_CYCLES > 1) ? $clog2(TRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(TRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Left-rotate a lane word by k bits; k=0 leaves it unchanged because a
  // right shift by the full width yields zero.
  function automatic logic [7:0] rot8(input logic [7:0] w, input logic [2:0] k);
    return (w << k) | (w >> (4'd8 - {1'b0, k}));
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   held_q, held_d;
  logic [2:0]    rot_q, rot_d;
  logic [1:0]    lock_q, lock_d;
  logic [7:0]    frm_q, frm_d;
  logic [7:0]    lane_a_q, lane_a_d;
  logic [7:0]    lane_b_q, lane_b_d;
  logic          training_q, training_d;
  logic          underflow_q, underflow_d;
  logic          handshake_s;

  assign sample_ready = (state_q == ST_RUN);
  assign handshake_s  = sample_valid & sample_ready;

  // FSM state and training counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: PLL loss dominates, then training restart, then the
  // normal IDLE -> TRAIN -> RUN progression
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!tx_pll_locked) begin
      state_d = ST_IDLE;
    end else if (train_req && (state_q != ST_IDLE)) begin
      state_d = ST_TRAIN;
      cnt_d   = CNT_LOAD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_TRAIN;
          cnt_d   = CNT_LOAD;
        end
        ST_TRAIN: begin
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Slip injection with a 3-cycle lockout, and the held sample register
  always_comb begin
    rot_d  = rot_q;
    lock_d = lock_q;
    if (slip_inject && (lock_q == 2'd0)) begin
      rot_d  = rot_q + 3'd1;
      lock_d = 2'd3;
    end else if (lock_q != 2'd0) begin
      lock_d = lock_q - 2'd1;
    end else begin
      lock_d = 2'd0;
    end
    if (handshake_s) begin
      held_d = sample_data;
    end else begin
      held_d = held_q;
    end
  end

  // Output logic: words are built for the state being entered, using the
  // rotation that becomes current on the same edge
  always_comb begin
    frm_d       = 8'h00;
    lane_a_d    = 8'h00;
    lane_b_d    = 8'h00;
    training_d  = 1'b0;
    underflow_d = 1'b0;
    case (state_d)
      ST_IDLE: begin
        frm_d = 8'h00;
      end
      ST_TRAIN: begin
        frm_d      = rot8(FRAME_PATTERN, rot_d);
        lane_a_d   = rot8(TEST_PATTERN[15:8], rot_d);
        lane_b_d   = rot8(TEST_PATTERN[7:0], rot_d);
        training_d = 1'b1;
      end
      ST_RUN: begin
        frm_d       = rot8(FRAME_PATTERN, rot_d);
        lane_a_d    = rot8(held_d[15:8], rot_d);
        lane_b_d    = rot8(held_d[7:0], rot_d);
        // Only a RUN cycle that stays in RUN can starve the stream
        underflow_d = (state_q == ST_RUN) && !sample_valid;
      end
      default: begin
        frm_d = 8'h00;
      end
    endcase
  end

  // Datapath and registered output update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_q      <= 16'h0000;
      rot_q       <= 3'd0;
      lock_q      <= 2'd0;
      frm_q       <= 8'h00;
      lane_a_q    <= 8'h00;
      lane_b_q    <= 8'h00;
      training_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      held_q      <= held_d;
      rot_q       <= rot_d;
      lock_q      <= lock_d;
      frm_q       <= frm_d;
      lane_a_q    <= lane_a_d;
      lane_b_q    <= lane_b_d;
      training_q  <= training_d;
      underflow_q <= underflow_d;
    end
  end

  assign frm_out    = frm_q;
  assign lane_a_out = lane_a_q;
  assign lane_b_out = lane_b_q;
  assign training   = training_q;
  assign underflow  = underflow_q;
  assign rot_offset = rot_q;

endmodule
